// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe: two-stage pipelined SIMD ALU.
// One opcode is applied across LANES independent WIDTH-bit two's complement
// lanes. Stage 1 registers the operand beat, stage 2 computes and registers
// the per-lane result and flags. Both ends use valid/ready with full
// backpressure; out_ready feeds in_ready combinationally for 1 beat/cycle.
// Optional build macro VALU_SAT_EN: ADD and SUB saturate per lane on signed
// overflow instead of wrapping (overflow flag behaviour is unchanged).
module vector_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             op,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       zero,
  output logic [LANES-1:0]       overflow,
  output logic                   illegal
);

  typedef enum logic [5:0] {
    OP_ADD = 6'b000000,
    OP_SUB = 6'b000001,
    OP_MUL = 6'b000010,
    OP_AND = 6'b000100,
    OP_OR  = 6'b000101,
    OP_XOR = 6'b000110,
    OP_SHL = 6'b001000,
    OP_SHR = 6'b001001,
    OP_SLT = 6'b001010,
    OP_SEQ = 6'b001011
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
  } lane_t;

  localparam logic [WIDTH-1:0] LP_SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LP_SMIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LP_WIDTH = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] LP_ONE   = WIDTH'(1);

  // Defined opcodes; everything else is flagged illegal.
  function automatic logic is_legal(input logic [5:0] f_op);
    case (f_op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_SLT, OP_SEQ: is_legal = 1'b1;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

  // Single-lane datapath: result plus signed-overflow flag.
  function automatic lane_t lane_op(input logic [5:0]       f_op,
                                    input logic [WIDTH-1:0] f_a,
                                    input logic [WIDTH-1:0] f_b);
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic               ovf_add;
    logic               ovf_sub;
    logic               mul_fits;
    lane_t              r;
    sum      = f_a + f_b;
    diff     = f_a - f_b;
    // Sign-extended to 2*WIDTH so the low 2*WIDTH bits are the signed product.
    prod     = {{WIDTH{f_a[WIDTH-1]}}, f_a} * {{WIDTH{f_b[WIDTH-1]}}, f_b};
    ovf_add  = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (sum[WIDTH-1] != f_a[WIDTH-1]);
    ovf_sub  = (f_a[WIDTH-1] != f_b[WIDTH-1]) && (diff[WIDTH-1] != f_a[WIDTH-1]);
    // Product fits when the top WIDTH+1 bits are all copies of the sign.
    mul_fits = (&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]);
    r = '0;
    case (f_op)
      OP_ADD: begin
        r.res = sum;
        r.ovf = ovf_add;
`ifdef VALU_SAT_EN
        // Overflow direction follows the sign of a (both operands share it).
        if (ovf_add) r.res = f_a[WIDTH-1] ? LP_SMIN : LP_SMAX;
`endif
      end
      OP_SUB: begin
        r.res = diff;
        r.ovf = ovf_sub;
`ifdef VALU_SAT_EN
        // Positive a minus negative b can only overflow upward, and vice versa.
        if (ovf_sub) r.res = f_a[WIDTH-1] ? LP_SMIN : LP_SMAX;
`endif
      end
      OP_MUL: begin
        r.res = prod[WIDTH-1:0];
        r.ovf = !mul_fits;
      end
      OP_AND: r.res = f_a & f_b;
      OP_OR:  r.res = f_a | f_b;
      OP_XOR: r.res = f_a ^ f_b;
      OP_SHL: r.res = (f_b >= LP_WIDTH) ? '0 : (f_a << f_b);
      OP_SHR: r.res = (f_b >= LP_WIDTH) ? '0 : (f_a >> f_b);
      OP_SLT: r.res = ($signed(f_a) < $signed(f_b)) ? LP_ONE : '0;
      OP_SEQ: r.res = (f_a == f_b) ? LP_ONE : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage-1 (operand) registers
  logic                   r_s1_valid;
  logic [5:0]             r_s1_op;
  logic [LANES*WIDTH-1:0] r_s1_a;
  logic [LANES*WIDTH-1:0] r_s1_b;

  // Stage-2 (result) registers
  logic                   r_out_valid;
  logic [LANES*WIDTH-1:0] r_result;
  logic [LANES-1:0]       r_zero;
  logic [LANES-1:0]       r_overflow;
  logic                   r_illegal;

  // Combinational compute of stage-1 contents
  logic [LANES*WIDTH-1:0] w_res;
  logic [LANES-1:0]       w_zero;
  logic [LANES-1:0]       w_ovf;
  logic                   w_illegal;
  logic                   w_s2_load;
  logic                   w_in_fire;

  // Stage 2 takes a new beat whenever it is empty or being drained this cycle.
  assign w_s2_load = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_fire = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

  // Per-lane compute on the stage-1 beat; zero derives from the final lane value.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    w_res     = '0;
    w_zero    = '0;
    w_ovf     = '0;
    w_illegal = !is_legal(r_s1_op);
    for (int i = 0; i < LANES; i++) begin
      {w_res[i*WIDTH +: WIDTH], w_ovf[i]} =
        lane_op(r_s1_op, r_s1_a[i*WIDTH +: WIDTH], r_s1_b[i*WIDTH +: WIDTH]);
      w_zero[i] = (w_res[i*WIDTH +: WIDTH] == '0);
    end
  end

  // Stage 1: capture an accepted beat; drop valid when it moves on with nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      // NOTE: data registers are reset as well as valids, so outputs read 0
      // after reset and no X leaks into the compute path.
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_op <= op;
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  // Stage 2: register result and flags; hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= '0;
      r_overflow  <= '0;
      r_illegal   <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result   <= w_res;
        r_zero     <= w_zero;
        r_overflow <= w_ovf;
        r_illegal  <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_vector_alu_pipe.sv
// tb_vector_alu_pipe: self-checking bench for vector_alu_pipe (WIDTH=8, LANES=4).
// A monitor logs every accepted input beat (through an integer-arithmetic
// reference model) and every accepted output beat; each test task drives its
// scenario and compares the two logs plus scenario-specific observations.
module tb_vector_alu_pipe;

  localparam int W = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [5:0]     op = '0;
  logic [L*W-1:0] a = '0;
  logic [L*W-1:0] b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [L*W-1:0] result;
  logic [L-1:0]   zero;
  logic [L-1:0]   overflow;
  logic           illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [L*W-1:0] res;
    logic [L-1:0]   z;
    logic [L-1:0]   ov;
    logic           ill;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t hold;
  bit    hold_valid = 0;
  int    stall_viol = 0;

  localparam logic [5:0] LEGAL_OPS [10] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5,
                                            6'd6, 6'd8, 6'd9, 6'd10, 6'd11};

  vector_alu_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Reference model: each lane computed with plain integer arithmetic.
  function automatic beat_t model(input logic [5:0] f_op,
                                  input logic [L*W-1:0] fa,
                                  input logic [L*W-1:0] fb);
    beat_t  r;
    longint sa, sb, ua, ub, full;
    longint maxv, minv;
    logic [63:0] bits;
    bit     ovf, legal;
    maxv = (64'sd1 <<< (W-1)) - 1;
    minv = -(64'sd1 <<< (W-1));
    r = '0;
    legal = 1;
    for (int i = 0; i < L; i++) begin
      sa = longint'($signed(fa[i*W +: W]));
      sb = longint'($signed(fb[i*W +: W]));
      ua = longint'({56'd0, fa[i*W +: W]});
      ub = longint'({56'd0, fb[i*W +: W]});
      ovf = 0;
      case (f_op)
        6'd0: begin
          full = sa + sb;
          ovf = (full > maxv) || (full < minv);
`ifdef VALU_SAT_EN
          if (ovf) full = (full > maxv) ? maxv : minv;
`endif
        end
        6'd1: begin
          full = sa - sb;
          ovf = (full > maxv) || (full < minv);
`ifdef VALU_SAT_EN
          if (ovf) full = (full > maxv) ? maxv : minv;
`endif
        end
        6'd2: begin
          full = sa * sb;
          ovf = (full > maxv) || (full < minv);
        end
        6'd4:  full = ua & ub;
        6'd5:  full = ua | ub;
        6'd6:  full = ua ^ ub;
        6'd8:  full = (ub >= W) ? 0 : (ua << ub);
        6'd9:  full = (ub >= W) ? 0 : (ua >> ub);
        6'd10: full = (sa < sb) ? 1 : 0;
        6'd11: full = (ua == ub) ? 1 : 0;
        default: begin
          full = 0;
          legal = 0;
        end
      endcase
      bits = full;
      r.res[i*W +: W] = bits[W-1:0];
      r.z[i]  = (bits[W-1:0] == '0);
      r.ov[i] = ovf;
    end
    r.ill = !legal;
    return r;
  endfunction

  // Monitor: log handshakes (sampled mid-cycle) and flag output changes during a stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_valid = 0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
      if (out_valid && out_ready) obs_q.push_back({result, zero, overflow, illegal});
      if (hold_valid && (!out_valid || ({result, zero, overflow, illegal} != hold)))
        stall_viol++;
      if (out_valid && !out_ready) begin
        hold = {result, zero, overflow, illegal};
        hold_valid = 1;
      end else begin
        hold_valid = 0;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted (bounded); in_valid stays high.
  task automatic send_beat(input logic [5:0] o, input logic [L*W-1:0] x,
                           input logic [L*W-1:0] y);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      next_cycle();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 for 64 cycles, required 1");
    end
  endtask

  // Let every accepted beat come out, then a few extra cycles to expose duplicates.
  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && (exp_q.size() != obs_q.size()); t++) next_cycle();
    repeat (4) next_cycle();
  endtask

  function automatic logic [5:0] rand_op();
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return LEGAL_OPS[$urandom_range(0, 9)];
  endfunction

  function automatic logic [L*W-1:0] rand_b(input logic [5:0] o);
    logic [L*W-1:0] v;
    v = $urandom();
    if (o == 6'd8 || o == 6'd9)
      for (int i = 0; i < L; i++) v[i*W +: W] = W'($urandom_range(0, 10));
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, result, zero, overflow, illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b res=%h z=%b ov=%b ill=%b, required all 0",
               out_valid, result, zero, overflow, illegal);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_add();
    logic [L*W-1:0] exp_res;
`ifdef VALU_SAT_EN
    exp_res = {8'h00, 8'h80, 8'h7F, 8'h02};
`else
    exp_res = {8'h00, 8'h7F, 8'h80, 8'h02};
`endif
    exp_q.delete();
    obs_q.delete();
    send_beat(6'd0, {8'hFF, 8'h80, 8'h7F, 8'h01}, {8'h01, 8'hFF, 8'h01, 8'h01});
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
    end
    next_cycle();
    n_checks++;
    if ({out_valid, result, overflow, zero, illegal} !== {1'b1, exp_res, 4'b0110, 4'b1000, 1'b0}) begin
      n_fail++;
      $display("FAIL add_directed: got valid=%b res=%h ov=%b z=%b ill=%b, required 1 %h 0110 1000 0",
               out_valid, result, overflow, zero, illegal, exp_res);
    end
    for (int k = 0; k < 30; k++) begin
      logic [L*W-1:0] ra;
      ra = $urandom();
      send_beat(($urandom_range(0, 1) == 0) ? 6'd0 : 6'd1, ra, $urandom());
    end
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL add_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL add_beat %0d: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_ops();
    exp_q.delete();
    obs_q.delete();
    send_beat(6'd2,  {8'h00, 8'h00, 8'hFE, 8'h10}, {8'h00, 8'h00, 8'h03, 8'h10});
    send_beat(6'd8,  {8'h00, 8'h00, 8'h81, 8'h81}, {8'h00, 8'h00, 8'h08, 8'h01});
    send_beat(6'd9,  {8'h00, 8'h00, 8'h81, 8'h81}, {8'h00, 8'h00, 8'h08, 8'h01});
    send_beat(6'd10, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'h00, 8'h01});
    send_beat(6'd11, {8'h00, 8'h00, 8'h00, 8'h5A}, {8'h00, 8'h00, 8'h00, 8'h5A});
    drain();
    n_checks++;
    if (obs_q.size() != 5) begin
      n_fail++;
      $display("FAIL ops_count: got %0d beats, required 5", obs_q.size());
    end else begin
      n_checks++;
      if ({obs_q[0].res[15:0], obs_q[0].ov[1:0], obs_q[0].z[1:0]} !== {16'hFA00, 2'b01, 2'b01}) begin
        n_fail++;
        $display("FAIL mul_directed: got res=%h ov=%b z=%b, required FA00 01 01",
                 obs_q[0].res[15:0], obs_q[0].ov[1:0], obs_q[0].z[1:0]);
      end
      n_checks++;
      if ({obs_q[1].res[15:0], obs_q[2].res[15:0]} !== {16'h0002, 16'h0040}) begin
        n_fail++;
        $display("FAIL shift_directed: got shl=%h shr=%h, required 0002 0040",
                 obs_q[1].res[15:0], obs_q[2].res[15:0]);
      end
      n_checks++;
      if ({obs_q[3].res[7:0], obs_q[4].res[7:0]} !== {8'h01, 8'h01}) begin
        n_fail++;
        $display("FAIL cmp_directed: got slt=%h seq=%h, required 01 01",
                 obs_q[3].res[7:0], obs_q[4].res[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    for (int k = 0; k < 60; k++) begin
      logic [5:0] o;
      o = LEGAL_OPS[$urandom_range(2, 9)];
      send_beat(o, $urandom(), rand_b(o));
    end
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL ops_rand_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL ops_beat %0d: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    exp_q.delete();
    obs_q.delete();
    send_beat(6'h3F, $urandom(), $urandom());
    send_beat(6'd0, $urandom(), $urandom());
    drain();
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL illegal_count: got %0d beats, required 2", obs_q.size());
    end else begin
      n_checks++;
      if ({obs_q[0].res, obs_q[0].z, obs_q[0].ov, obs_q[0].ill} !== {32'h0, 4'hF, 4'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL illegal_beat: got res=%h z=%b ov=%b ill=%b, required 0 1111 0000 1",
                 obs_q[0].res, obs_q[0].z, obs_q[0].ov, obs_q[0].ill);
      end
      n_checks++;
      if (obs_q[1] !== exp_q[1] || obs_q[1].ill !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_next_add: got %h, required %h", obs_q[1], exp_q[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]     bop [8];
    logic [L*W-1:0] ba  [8];
    logic [L*W-1:0] bb  [8];
    int accepted, delivered, last_acc_cyc, outstanding_at_low;
    bit low_seen;
    for (int i = 0; i < 8; i++) begin
      bop[i] = LEGAL_OPS[$urandom_range(0, 9)];
      ba[i]  = $urandom();
      bb[i]  = rand_b(bop[i]);
    end
    exp_q.delete();
    obs_q.delete();
    stall_viol = 0;
    accepted = 0;
    delivered = 0;
    last_acc_cyc = -1;
    outstanding_at_low = -1;
    low_seen = 0;
    for (int cyc = 0; cyc < 60 && delivered < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid = (accepted < 8);
      if (accepted < 8) begin
        op = bop[accepted];
        a  = ba[accepted];
        b  = bb[accepted];
      end
      @(negedge clk);
      if (in_valid && !in_ready && !low_seen) begin
        low_seen = 1;
        outstanding_at_low = accepted - delivered;
      end
      if (in_valid && in_ready) begin
        accepted++;
        last_acc_cyc = cyc;
      end
      if (out_valid && out_ready) delivered++;
      next_cycle();
    end
    drain();
    n_checks++;
    if (!low_seen || outstanding_at_low != 2) begin
      n_fail++;
      $display("FAIL b2b_in_ready_drop: seen=%0d outstanding=%0d, required 1 and 2",
               low_seen, outstanding_at_low);
    end
    n_checks++;
    if (last_acc_cyc != 11) begin
      n_fail++;
      $display("FAIL b2b_throughput: last beat accepted in cycle %0d, required 11", last_acc_cyc);
    end
    n_checks++;
    if (stall_viol != 0) begin
      n_fail++;
      $display("FAIL b2b_stall_hold: %0d output changes during stall, required 0", stall_viol);
    end
    n_checks++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d out / %0d in, required 8 / 8", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b_beat %0d: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b1;
    send_beat(6'd0, $urandom(), $urandom());
    send_beat(6'd1, $urandom(), $urandom());
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_setup: out_valid=%b before reset, required 1", out_valid);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, result, illegal} !== '0) begin
      n_fail++;
      $display("FAIL inflight_reset: got valid=%b res=%h ill=%b, required 0", out_valid, result, illegal);
    end
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) next_cycle();
    n_checks++;
    if (obs_q.size() != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_stale: got %0d beats in_ready=%b, required 0 beats in_ready=1",
               obs_q.size(), in_ready);
    end
    send_beat(6'd0, $urandom(), $urandom());
    drain();
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL inflight_after_count: got %0d beats, required 1", obs_q.size());
    end else if (obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL inflight_after_beat: got %h, required %h", obs_q[0], exp_q[0]);
    end
  endtask

  task automatic test_random();
    int sent;
    bit need_new;
    exp_q.delete();
    obs_q.delete();
    stall_viol = 0;
    sent = 0;
    need_new = 1;
    for (int cyc = 0; cyc < 5000 && sent < 300; cyc++) begin
      if (need_new) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = rand_op();
        a  = $urandom();
        b  = rand_b(op);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        need_new = 1;
      end else begin
        need_new = !in_valid;
      end
      next_cycle();
    end
    drain();
    n_checks++;
    if (stall_viol != 0) begin
      n_fail++;
      $display("FAIL rand_stall_hold: %0d output changes during stall, required 0", stall_viol);
    end
    n_checks++;
    if (sent != 300 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: sent %0d got %0d required %0d", sent, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand_beat %0d: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_illegal();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
